// File: rtl/mem_dma.sv
// ============================================================================
// Module   : mem_dma
// Purpose  : Word-granular memory-to-memory copy engine. Each word takes one
//            READ cycle (RD captured) followed by one WRITE cycle, walking
//            source and destination upward by BYTE_SIZE bytes per word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request a copy (accepted only while idle)
//   abort    - stop the copy in progress
//   SRC/DST  - source / destination byte addresses
//   LEN      - number of words to copy
//   ADDR     - byte address to the memory
//   WE/WD    - memory write enable / write data
//   RD       - memory read data, combinational from ADDR
//   busy     - high whenever not idle
//   done     - one-cycle completion pulse
//   aborted  - copy ended by abort; held until the next accepted start
//   count    - words written in the current or last copy
//   checksum - XOR of all written words (only with MEM_DMA_CHECKSUM_EN)
// Build option:
//   MEM_DMA_CHECKSUM_EN - adds the checksum output and its accumulator
// ============================================================================
`default_nettype none

module mem_dma #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  SRC,
  input  logic [ADDR_WIDTH-1:0]  DST,
  input  logic [LEN_WIDTH-1:0]   LEN,
  output logic [ADDR_WIDTH-1:0]  ADDR,
  output logic                   WE,
  output logic [BYTE_SIZE*8-1:0] WD,
  input  logic [BYTE_SIZE*8-1:0] RD,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [LEN_WIDTH-1:0]   count
`ifdef MEM_DMA_CHECKSUM_EN
  ,
  output logic [BYTE_SIZE*8-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] c_STEP = ADDR_WIDTH'(BYTE_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_src;
  logic [ADDR_WIDTH-1:0]  r_dst;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [BYTE_SIZE*8-1:0] r_data;
  logic [LEN_WIDTH-1:0]   r_count;
  logic                   r_aborted;
  logic                   w_accept;
  logic [LEN_WIDTH-1:0]   w_count_inc;
  logic                   w_last;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_count_inc = r_count + 1'b1;
  // The word being written now is the final one when count+1 reaches LEN.
  assign w_last      = (w_count_inc == r_len);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and memory-side outputs. Outputs decode from the state only,
  // so an asynchronous reset drops WE/ADDR/WD in the same instant.
  always_comb begin
    w_next = r_state;
    ADDR   = '0;
    WE     = 1'b0;
    WD     = '0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (LEN == '0) ? FIN : READ;
        end
      end
      READ: begin
        ADDR   = r_src;
        w_next = abort ? FIN : WRITE;
      end
      WRITE: begin
        ADDR   = r_dst;
        WE     = 1'b1;
        WD     = r_data;
        // An abort here still lets the current write complete.
        w_next = (abort || w_last) ? FIN : READ;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latched request, read buffer, progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_count   <= '0;
      r_aborted <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src     <= SRC;
        r_dst     <= DST;
        r_len     <= LEN;
        r_count   <= '0;
        r_aborted <= 1'b0;
      end
      if (r_state == READ) begin
        r_data <= RD;
        if (abort) begin
          r_aborted <= 1'b1;
        end
      end
      if (r_state == WRITE) begin
        // Addresses wrap naturally at 2^ADDR_WIDTH.
        r_src   <= r_src + c_STEP;
        r_dst   <= r_dst + c_STEP;
        r_count <= w_count_inc;
        if (abort) begin
          r_aborted <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_DMA_CHECKSUM_EN
  logic [BYTE_SIZE*8-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum ^ r_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign busy    = (r_state != IDLE);
  assign aborted = r_aborted;
  assign count   = r_count;

endmodule

`default_nettype wire
